keypad_entry: RTL and testbench
===============================

KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 The block SHALL have parameter SCAN_DIV_BITS, default 16, meaning the scan tick period is 2^SCAN_DIV_BITS clk cycles.
REQ-002 The block SHALL have parameter DEBOUNCE_SCANS, default 4, meaning the number of consecutive stable scan ticks required to accept a press or a release.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port col, output, 4 bits: keypad column drive; exactly one bit is low at a time.
REQ-006 The block SHALL have port row, input, 4 bits: keypad row sense; active-low, externally pulled up, asynchronous.
REQ-007 The block SHALL have port entry, output, 19 bits: live value being typed.
REQ-008 The block SHALL have port ndigits, output, 3 bits: number of digits currently in entry (0..6).
REQ-009 The block SHALL have port num, output, 19 bits: last committed value, in the same format consumed by the 6-digit display driver.
REQ-010 The block SHALL have port valid, output, 1 bit: one-cycle pulse when num is updated by ENTER.
REQ-011 The block SHALL have port err, output, 1 bit: one-cycle pulse when a digit is rejected.

Function
REQ-012 row SHALL pass through a 2-flop synchronizer before any use.
REQ-013 A free-running divider SHALL assert a one-cycle tick every 2^SCAN_DIV_BITS cycles.
REQ-014 In SCAN, on each tick, the block SHALL sample the synchronized row for the driven column, then rotate col 1110->1101->1011->0111->1110.
REQ-015 If any row bit is low at the sample, code={col_idx,row_idx} SHALL be latched, the lowest low row index SHALL win, col SHALL freeze, and the state SHALL go to DEBOUNCE.
REQ-016 In DEBOUNCE, a counter SHALL count ticks with the same code; reaching DEBOUNCE_SCANS SHALL go to PRESSED, and a differing or absent code SHALL return to SCAN with the counter cleared.
REQ-017 PRESSED SHALL last exactly one clk cycle, execute the key action, and go to WAIT_RELEASE.
REQ-018 In WAIT_RELEASE, the block SHALL leave only after DEBOUNCE_SCANS consecutive ticks with all rows high, then go to SCAN; a held key SHALL act exactly once.
REQ-019 The key map SHALL come from the package: codes decoding to 0-9 are DIGIT, 0xA is CLEAR, 0xB is BACKSPACE, 0xE is ENTER, and all others are ignored.
REQ-020 DIGIT d: if ndigits<6 and entry*10+d <= 524287 (computed 23 bits wide), then entry<=entry*10+d and ndigits++; otherwise entry and ndigits SHALL be unchanged and err SHALL pulse.
REQ-021 CLEAR SHALL set entry<=0 and ndigits<=0.
REQ-022 BACKSPACE: if ndigits>0, entry<=entry/10 and ndigits--; if ndigits=0 there SHALL be no effect.
REQ-023 ENTER SHALL set num<=entry, pulse valid, and set entry<=0 and ndigits<=0; ENTER with ndigits=0 SHALL commit 0 and pulse valid.
REQ-024 valid and err SHALL never assert in the same cycle, and each SHALL be high for at most one cycle per press.
REQ-025 Leading zeros SHALL count as digits (typing 0,0,7 gives ndigits=3 and entry=7).

Reset
REQ-026 With rst=0 at a clk edge, the block SHALL set: col=4'b1110, entry=0, ndigits=0, num=0, valid=0, err=0, state=SCAN, divider=0, debounce counter=0, synchronizer=4'b1111.
REQ-027 Reset mid-DEBOUNCE or mid-WAIT_RELEASE SHALL abandon the key without action; a key still held after reset SHALL be treated as a new press.

Configuration
REQ-028 Macro KEYPAD_ENTRY_ECHO_EN: when defined, num SHALL continuously equal entry, except in the cycle of valid, when it equals the committed value; num then holds that value until the next keypress changes entry.
REQ-029 Without KEYPAD_ENTRY_ECHO_EN, num SHALL change only on ENTER.
REQ-030 valid, err, and entry behaviour SHALL be identical in both builds.

Structure
REQ-031 Package keypad_pkg SHALL hold: the state enum (SCAN, DEBOUNCE, PRESSED, WAIT_RELEASE), the 16-entry code-to-key map, key-class constants, MAX_VALUE=524287, and MAX_DIGITS=6.
REQ-032 Sub-module keypad_scan SHALL contain: divider, column rotation, synchronizer, debounce FSM; it SHALL output key_code and key_stb (one-cycle pulse in PRESSED).
REQ-033 keypad_entry SHALL contain: accumulator, digit count, commit logic, err/valid generation.

Verification (SCAN_DIV_BITS=2, DEBOUNCE_SCANS=2)
REQ-034 Bench SHALL press keys 1,2,3, then ENTER -> entry 1,12,123; ndigits 3; num=123; valid one pulse; entry=0 after.
REQ-035 Bench SHALL press 5,2,4,2,8,7, then 9 -> entry=524287 and ndigits=6; the 9 gives err pulse and no change; 9 after CLEAR+5,2,4,2,8 gives 52428*10+9=524289 > MAX -> err.
REQ-036 Bench SHALL press 4,5, BACKSPACE, BACKSPACE, BACKSPACE -> entry 4 then 0; the third BACKSPACE has no effect and no err.
REQ-037 Bench SHALL hold key 7 for 50 ticks with 1-tick bounce at press and release -> exactly one digit accepted (entry=7).
REQ-038 Bench SHALL hold rst=0 during DEBOUNCE of key 3 with 3 still held after release of reset -> outputs at reset values, then entry=3 after debounce.
REQ-039 Bench SHALL check the ECHO_EN build -> num tracks entry (1,12); without the macro num stays 0 until ENTER.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad entry block.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
//
// Contents:
//   scan_state_t - scanner FSM states
//   key_class_t  - what a decoded key does
//   key_t        - decoded key (class + 4-bit value)
//   KEY_MAP      - 16-entry map from scan code {col_idx,row_idx} to key value
//   MAX_VALUE    - largest value the display path can show (19 bits)
//   MAX_DIGITS   - maximum number of typed digits
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } scan_state_t;

    typedef enum logic [2:0] {
        KC_NONE  = 3'd0,
        KC_DIGIT = 3'd1,
        KC_CLEAR = 3'd2,
        KC_BKSP  = 3'd3,
        KC_ENTER = 3'd4
    } key_class_t;

    typedef struct packed {
        key_class_t kclass;
        logic [3:0] value;
    } key_t;

    localparam int          ENTRY_W    = 19;
    localparam int          PROD_W     = 23;
    localparam logic [18:0] MAX_VALUE  = 19'd524287;
    localparam logic [2:0]  MAX_DIGITS = 3'd6;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    // Physical layout (row r, column c):
    //   r0:  1  2  3  A
    //   r1:  4  5  6  B
    //   r2:  7  8  9  C
    //   r3:  E  0  F  D
    // Indexed by code = {col_idx, row_idx}, i.e. column-major.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'hE,     // column 0
        4'h2, 4'h5, 4'h8, 4'h0,     // column 1
        4'h3, 4'h6, 4'h9, 4'hF,     // column 2
        4'hA, 4'hB, 4'hC, 4'hD      // column 3
    };

    function automatic key_t key_decode(input logic [3:0] code);
        key_t k;
        k.value = KEY_MAP[code];
        if (k.value <= 4'd9) begin
            k.kclass = KC_DIGIT;
        end else if (k.value == KEY_CLEAR) begin
            k.kclass = KC_CLEAR;
        end else if (k.value == KEY_BKSP) begin
            k.kclass = KC_BKSP;
        end else if (k.value == KEY_ENTER) begin
            k.kclass = KC_ENTER;
        end else begin
            k.kclass = KC_NONE;
        end
        return k;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// Column scanner, row synchronizer and debouncer for a 4x4 matrix keypad.
// Latency: a key is reported DEBOUNCE_SCANS scan ticks after it is first seen.
// Backpressure: none; key_stb is a one-cycle pulse that must be consumed.
//
// Ports:
//   clk, rst       - clock, synchronous active-low reset
//   row[3:0]       - raw row sense (active-low, asynchronous)
//   col[3:0]       - column drive, exactly one bit low
//   key_code[3:0]  - {col_idx,row_idx} of the accepted key, valid with key_stb
//   key_stb        - one-cycle pulse while the FSM is in PRESSED
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_stb
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    scan_state_t              state;
    logic [SCAN_DIV_BITS-1:0] div;
    logic                     tick;
    logic [3:0]               row_meta;
    logic [3:0]               row_sync;
    logic [1:0]               col_idx;
    logic [CNT_W-1:0]         cnt;
    logic                     row_hit;
    logic [1:0]               row_idx;

    // Divider wraps every 2^SCAN_DIV_BITS cycles; the tick is its last count.
    assign tick = &div;

    // Lowest-numbered low row wins when several keys share a column.
    always_comb begin
        row_hit = (row_sync != 4'hF);
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_sync[i]) begin
                row_idx = 2'(i);
            end
        end
    end

    // The column only moves on a tick, so by the next tick the synchronized
    // rows already reflect the column currently being driven.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= SCAN;
            div      <= '0;
            cnt      <= '0;
            col_idx  <= 2'd0;
            col      <= 4'b1110;
            key_code <= 4'd0;
            key_stb  <= 1'b0;
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            div      <= div + 1'b1;
            row_meta <= row;
            row_sync <= row_meta;
            key_stb  <= 1'b0;

            case (state)
                SCAN: begin
                    if (tick) begin
                        if (row_hit) begin
                            // Freeze the column on the candidate key.
                            key_code <= {col_idx, row_idx};
                            cnt      <= '0;
                            state    <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 1'b1;
                            col     <= {col[2:0], col[3]};
                        end
                    end
                end

                DEBOUNCE: begin
                    if (tick) begin
                        if (row_hit && (row_idx == key_code[1:0])) begin
                            if (cnt == CNT_LAST) begin
                                cnt     <= '0;
                                key_stb <= 1'b1;
                                state   <= PRESSED;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            // Bounce or a different key: resume scanning.
                            cnt   <= '0;
                            state <= SCAN;
                        end
                    end
                end

                PRESSED: begin
                    state <= WAIT_RELEASE;
                end

                WAIT_RELEASE: begin
                    // Column stays frozen, so "all rows high" means the
                    // accepted key has let go; any low sample restarts the count.
                    if (tick) begin
                        if (!row_hit) begin
                            if (cnt == CNT_LAST) begin
                                cnt   <= '0;
                                state <= SCAN;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad number entry: scans a 4x4 keypad and builds a decimal value of up to 6 digits.
// Latency: entry/ndigits/num/valid/err update one cycle after the scanner strobes a key.
// Backpressure: none; valid and err are single-cycle pulses with no handshake.
//
// Ports:
//   clk, rst       - clock, synchronous active-low reset
//   col[3:0]       - keypad column drive (one bit low)
//   row[3:0]       - keypad row sense (active-low, asynchronous)
//   entry[18:0]    - value currently being typed
//   ndigits[2:0]   - digits typed so far (leading zeros count)
//   num[18:0]      - last committed value for the 6-digit display
//   valid          - pulses when ENTER commits entry to num
//   err            - pulses when a digit is rejected (too many digits or too large)
//
// Build option KEYPAD_ENTRY_ECHO_EN: num echoes entry while typing; on ENTER it
// shows the committed value and holds it until a keypress changes entry.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic [3:0]         col,
    input  logic [3:0]         row,
    output logic [ENTRY_W-1:0] entry,
    output logic [2:0]         ndigits,
    output logic [ENTRY_W-1:0] num,
    output logic               valid,
    output logic               err
);

    logic [3:0]         key_code;
    logic               key_stb;
    key_t               key;
    logic [PROD_W-1:0]  prod;
    logic               digit_ok;
    logic [ENTRY_W-1:0] entry_nxt;
    logic [2:0]         ndigits_nxt;
    logic               commit;
    logic               reject;

    keypad_scan #(
        .SCAN_DIV_BITS  (SCAN_DIV_BITS),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_stb  (key_stb)
    );

    always_comb begin
        key  = key_decode(key_code);
        // 23 bits holds 524287*10+9 without wrapping, so the range test is exact.
        prod = PROD_W'(entry) * PROD_W'(10) + PROD_W'(key.value);
        digit_ok = (ndigits < MAX_DIGITS) && (prod <= PROD_W'(MAX_VALUE));

        entry_nxt   = entry;
        ndigits_nxt = ndigits;
        commit      = 1'b0;
        reject      = 1'b0;

        if (key_stb) begin
            case (key.kclass)
                KC_DIGIT: begin
                    if (digit_ok) begin
                        entry_nxt   = prod[ENTRY_W-1:0];
                        ndigits_nxt = ndigits + 3'd1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                KC_CLEAR: begin
                    entry_nxt   = '0;
                    ndigits_nxt = 3'd0;
                end
                KC_BKSP: begin
                    if (ndigits != 3'd0) begin
                        entry_nxt   = entry / ENTRY_W'(10);
                        ndigits_nxt = ndigits - 3'd1;
                    end
                end
                KC_ENTER: begin
                    commit      = 1'b1;
                    entry_nxt   = '0;
                    ndigits_nxt = 3'd0;
                end
                default: begin
                    entry_nxt   = entry;
                    ndigits_nxt = ndigits;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            entry   <= '0;
            ndigits <= 3'd0;
            num     <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            entry   <= entry_nxt;
            ndigits <= ndigits_nxt;
            valid   <= commit;
            err     <= reject;
            if (commit) begin
                num <= entry;
            end
`ifdef KEYPAD_ENTRY_ECHO_EN
            // Echo only real edits, so a committed value stays on the
            // display until the user starts typing the next one.
            else if ((entry_nxt != entry) || (ndigits_nxt != ndigits)) begin
                num <= entry_nxt;
            end
`endif
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed self-checking bench for keypad_entry (SCAN_DIV_BITS=2, DEBOUNCE_SCANS=2).
// A behavioural keypad pulls one row low while its column is driven low.
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [18:0] entry;
    logic [2:0]  ndigits;
    logic [18:0] num;
    logic        valid;
    logic        err;

    int errors = 0;
    int checks = 0;

    bit key_down = 1'b0;
    int key_c    = 0;
    int key_r    = 0;

    int nvalid  = 0;
    int nerr    = 0;
    int nboth   = 0;
    int nbadcol = 0;

    int lc = 0;   // last committed value

`ifdef KEYPAD_ENTRY_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    always #5 clk = ~clk;

    keypad_entry #(
        .SCAN_DIV_BITS  (2),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .col     (col),
        .row     (row),
        .entry   (entry),
        .ndigits (ndigits),
        .num     (num),
        .valid   (valid),
        .err     (err)
    );

    always_comb begin
        row = 4'hF;
        if (key_down && (col[key_c] == 1'b0)) begin
            row[key_r] = 1'b0;
        end
    end

    // Physical position of each key: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    task automatic set_key(input int k);
        case (k)
            1:    begin key_c = 0; key_r = 0; end
            4:    begin key_c = 0; key_r = 1; end
            7:    begin key_c = 0; key_r = 2; end
            'hE:  begin key_c = 0; key_r = 3; end
            2:    begin key_c = 1; key_r = 0; end
            5:    begin key_c = 1; key_r = 1; end
            8:    begin key_c = 1; key_r = 2; end
            0:    begin key_c = 1; key_r = 3; end
            3:    begin key_c = 2; key_r = 0; end
            6:    begin key_c = 2; key_r = 1; end
            9:    begin key_c = 2; key_r = 2; end
            'hF:  begin key_c = 2; key_r = 3; end
            'hA:  begin key_c = 3; key_r = 0; end
            'hB:  begin key_c = 3; key_r = 1; end
            'hC:  begin key_c = 3; key_r = 2; end
            default: begin key_c = 3; key_r = 3; end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Hold the key state for n cycles, sampling outputs on falling edges.
    task automatic run(input int n, input bit down);
        key_down = down;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid) nvalid++;
            if (err) nerr++;
            if (valid && err) nboth++;
            if (!(col inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) nbadcol++;
        end
    endtask

    task automatic press(input int k);
        set_key(k);
        nvalid = 0;
        nerr   = 0;
        run(60, 1'b1);
        run(40, 1'b0);
    endtask

    task automatic press_check(input int k, input int exp_e, input int exp_nd, input int exp_err);
        press(k);
        check($sformatf("key%0h entry", k), entry, exp_e);
        check($sformatf("key%0h ndigits", k), ndigits, exp_nd);
        check($sformatf("key%0h err_pulses", k), nerr, exp_err);
        check($sformatf("key%0h valid_pulses", k), nvalid, 0);
        check($sformatf("key%0h num", k), num, ECHO ? exp_e : lc);
    endtask

    task automatic enter_check(input int exp_num);
        press('hE);
        lc = exp_num;
        check("enter valid_pulses", nvalid, 1);
        check("enter err_pulses", nerr, 0);
        check("enter num", num, exp_num);
        check("enter entry", entry, 0);
        check("enter ndigits", ndigits, 0);
    endtask

    task automatic reset_values(input string tag);
        check({tag, " col"}, col, 4'b1110);
        check({tag, " entry"}, entry, 0);
        check({tag, " ndigits"}, ndigits, 0);
        check({tag, " num"}, num, 0);
        check({tag, " valid"}, valid, 0);
        check({tag, " err"}, err, 0);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        reset_values("reset");
        rst = 1'b1;

        // 1,2,3 then ENTER
        press_check(1, 1, 1, 0);
        press_check(2, 12, 2, 0);
        press_check(3, 123, 3, 0);
        enter_check(123);

        // Fill to six digits at the maximum, then overflow by digit count
        press_check(5, 5, 1, 0);
        press_check(2, 52, 2, 0);
        press_check(4, 524, 3, 0);
        press_check(2, 5242, 4, 0);
        press_check(8, 52428, 5, 0);
        press_check(7, 524287, 6, 0);
        press_check(9, 524287, 6, 1);

        // Overflow by value with only five digits
        press_check('hA, 0, 0, 0);
        press_check(5, 5, 1, 0);
        press_check(2, 52, 2, 0);
        press_check(4, 524, 3, 0);
        press_check(2, 5242, 4, 0);
        press_check(8, 52428, 5, 0);
        press_check(9, 52428, 5, 1);

        // Backspace down to empty and once more
        press_check('hA, 0, 0, 0);
        press_check(4, 4, 1, 0);
        press_check(5, 45, 2, 0);
        press_check('hB, 4, 1, 0);
        press_check('hB, 0, 0, 0);
        press_check('hB, 0, 0, 0);

        // Long hold of 7 with one-tick bounce at press and release
        set_key(7);
        nvalid = 0;
        nerr   = 0;
        run(4, 1'b1);
        run(4, 1'b0);
        run(200, 1'b1);
        run(4, 1'b0);
        run(4, 1'b1);
        run(60, 1'b0);
        check("hold7 entry", entry, 7);
        check("hold7 ndigits", ndigits, 1);
        check("hold7 err_pulses", nerr, 0);
        check("hold7 valid_pulses", nvalid, 0);

        // Unmapped key is ignored
        press_check('hC, 7, 1, 0);

        // Leading zeros count, then ENTER, then ENTER on empty entry
        press_check('hA, 0, 0, 0);
        press_check(0, 0, 1, 0);
        press_check(0, 0, 2, 0);
        press_check(7, 7, 3, 0);
        enter_check(7);
        enter_check(0);

        // Reset in the middle of debouncing a held key 3
        press_check(4, 4, 1, 0);
        set_key(3);
        key_down = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        lc = 0;
        nvalid = 0;
        nerr   = 0;
        run(15, 1'b1);
        check("rst_mid entry_before", entry, 0);
        check("rst_mid ndigits_before", ndigits, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        reset_values("rst_mid");
        rst = 1'b1;
        run(60, 1'b1);
        check("rst_mid entry_after", entry, 3);
        check("rst_mid ndigits_after", ndigits, 1);
        check("rst_mid num_after", num, ECHO ? 3 : 0);
        run(40, 1'b0);
        check("rst_mid err_pulses", nerr, 0);
        check("rst_mid valid_pulses", nvalid, 0);
        check("rst_mid entry_released", entry, 3);

        // Run-wide invariants
        check("valid_err_overlap", nboth, 0);
        check("col_not_onehot_low", nbadcol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
